// File: rtl/mont_precompute.sv
// Montgomery precompute engine: from an odd modulus n it derives
// R mod n, R^2 mod n and -n^-1 mod R (R = 2^WIDTH).
// The engine uses one shift-and-subtract iteration per cycle for 2*WIDTH cycles.
// The x register doubles modulo n on every iteration. It passes R mod n
// half way through the run and reaches R^2 mod n at the end.
// While the first WIDTH iterations run, a Hensel-style accumulator
// builds n_prime one bit per cycle.
module mont_precompute #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] mont_one,
    output logic [WIDTH-1:0] r2_mod_n,
    output logic [WIDTH-1:0] n_prime
);

    localparam int KW = $clog2(2 * WIDTH);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] x_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] t_reg;
    logic [WIDTH-1:0] np_reg;
    // ns_reg tracks n << k, so the accumulator needs no barrel shifter
    logic [WIDTH-1:0] ns_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;
    logic [WIDTH-1:0] mont_one_reg;
    logic [WIDTH-1:0] r2_reg;
    logic [WIDTH-1:0] n_prime_reg;

    logic [WIDTH-1:0] x_dbl_next;
    logic             x_ge_next;
    logic [WIDTH-1:0] x_next;
    logic             low_phase_next;
    logic             t_bit_next;
    logic [WIDTH-1:0] t_next;
    logic [WIDTH-1:0] np_next;
    logic             last_low_next;
    logic             last_next;
    logic             bad_mod_next;

    // Modular doubling and accumulator step for the current RUN iteration
    always_comb begin
        // x < n always holds, so 2x < 2n. The carry out of the doubling
        // therefore also means 2x >= n, and a single subtract brings 2x
        // back into range.
        x_dbl_next     = {x_reg[WIDTH-2:0], 1'b0};
        x_ge_next      = x_reg[WIDTH-1] | (x_dbl_next >= n_reg);
        x_next         = x_ge_next ? (x_dbl_next - n_reg) : x_dbl_next;
        low_phase_next = (k_reg < KW'(WIDTH));
        t_bit_next     = t_reg[k_reg[IW-1:0]];
        t_next         = t_reg + ns_reg;
        // n_prime bits enter at the top and shift down, so bit k reaches
        // position k after WIDTH iterations
        np_next        = {~t_bit_next, np_reg[WIDTH-1:1]};
        last_low_next  = (k_reg == KW'(WIDTH - 1));
        last_next      = (k_reg == KW'(2 * WIDTH - 1));
        bad_mod_next   = ~modulus[0] | (modulus == WIDTH'(1));
    end

    // Control FSM with datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            n_reg        <= '0;
            x_reg        <= '0;
            k_reg        <= '0;
            t_reg        <= '0;
            np_reg       <= '0;
            ns_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            mont_one_reg <= '0;
            r2_reg       <= '0;
            n_prime_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_reg    <= modulus;
                        busy_reg <= 1'b1;
                        if (bad_mod_next) begin
                            state_reg <= ERR;
                            done_reg  <= 1'b1;
                            error_reg <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            error_reg <= 1'b0;
                            x_reg     <= WIDTH'(1);
                            k_reg     <= '0;
                            t_reg     <= '0;
                            np_reg    <= '0;
                            ns_reg    <= modulus;
                        end
                    end
                end
                RUN: begin
                    x_reg  <= x_next;
                    k_reg  <= k_reg + KW'(1);
                    ns_reg <= {ns_reg[WIDTH-2:0], 1'b0};
                    if (low_phase_next) begin
                        np_reg <= np_next;
                        if (!t_bit_next) begin
                            t_reg <= t_next;
                        end
                    end
                    if (last_low_next) begin
                        mont_one_reg <= x_next;
                    end
                    if (last_next) begin
                        r2_reg      <= x_next;
                        n_prime_reg <= np_reg;
                        state_reg   <= DONE;
                        done_reg    <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign error    = error_reg;
    assign mont_one = mont_one_reg;
    assign r2_mod_n = r2_reg;
    assign n_prime  = n_prime_reg;

endmodule

// File: tb/tb_mont_precompute.sv
// Directed bench for mont_precompute at WIDTH=8.
module tb_mont_precompute;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] modulus;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] mont_one;
    logic [7:0] r2_mod_n;
    logic [7:0] n_prime;

    int checks;
    int failures;

    mont_precompute #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .mont_one (mont_one),
        .r2_mod_n (r2_mod_n),
        .n_prime  (n_prime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; returns 1ns after the accepting edge
    task automatic accept(input logic [7:0] n);
        @(posedge clk);
        #1;
        start   = 1'b1;
        modulus = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded at 40
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        modulus = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, error} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {busy, done, error});
        end
        checks++;
        if ({mont_one, r2_mod_n, n_prime} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=000000", {mont_one, r2_mod_n, n_prime});
        end
        rst = 1'b0;
        $display("reset: busy=%b done=%b error=%b", busy, done, error);
    endtask

    task automatic test_basic;
        int lat;
        accept(8'd13);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b want=1", busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=16", lat);
        end
        checks++;
        if ({mont_one, r2_mod_n, n_prime, error} !== {8'd9, 8'd3, 8'd59, 1'b0}) begin
            failures++;
            $display("FAIL basic_n13 got=%0d/%0d/%0d err=%b want=9/3/59 err=0",
                     mont_one, r2_mod_n, n_prime, error);
        end
        $display("n=13: lat=%0d mont_one=%0d r2=%0d n_prime=%0d", lat, mont_one, r2_mod_n, n_prime);
    endtask

    task automatic test_back_to_back;
        // start during the done cycle must be dropped
        start = 1'b1;
        modulus = 8'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_after_done got=%b want=00", {busy, done});
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_not_queued got=%b want=0", busy);
        end
        $display("back_to_back: busy=%b done=%b", busy, done);
    endtask

    task automatic test_vectors;
        logic [7:0] tn [2];
        logic [7:0] tm [2];
        logic [7:0] tr [2];
        logic [7:0] tp [2];
        int lat;
        tn[0] = 8'd255; tm[0] = 8'd1; tr[0] = 8'd1; tp[0] = 8'd1;
        tn[1] = 8'd3;   tm[1] = 8'd1; tr[1] = 8'd1; tp[1] = 8'd85;
        for (int i = 0; i < 2; i++) begin
            accept(tn[i]);
            wait_done(lat);
            checks++;
            if ({mont_one, r2_mod_n, n_prime} !== {tm[i], tr[i], tp[i]} || lat !== 16) begin
                failures++;
                $display("FAIL vec_n%0d got=%0d/%0d/%0d lat=%0d want=%0d/%0d/%0d lat=16",
                         tn[i], mont_one, r2_mod_n, n_prime, lat, tm[i], tr[i], tp[i]);
            end
            $display("n=%0d: mont_one=%0d r2=%0d n_prime=%0d", tn[i], mont_one, r2_mod_n, n_prime);
        end
    endtask

    task automatic test_error;
        logic [7:0] bad [2];
        bad[0] = 8'd12;
        bad[1] = 8'd1;
        for (int i = 0; i < 2; i++) begin
            accept(bad[i]);
            checks++;
            if ({done, error, busy} !== 3'b111) begin
                failures++;
                $display("FAIL err_n%0d_pulse got=%b want=111", bad[i], {done, error, busy});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({done, error, busy} !== 3'b010) begin
                failures++;
                $display("FAIL err_n%0d_after got=%b want=010", bad[i], {done, error, busy});
            end
            checks++;
            if ({mont_one, r2_mod_n, n_prime} !== {8'd1, 8'd1, 8'd85}) begin
                failures++;
                $display("FAIL err_n%0d_hold got=%0d/%0d/%0d want=1/1/85",
                         bad[i], mont_one, r2_mod_n, n_prime);
            end
            $display("n=%0d: error=%b results=%0d/%0d/%0d", bad[i], error, mont_one, r2_mod_n, n_prime);
        end
    endtask

    task automatic test_mid_run;
        int pulses;
        int first;
        logic [23:0] seen;
        pulses = 0;
        first = -1;
        seen = 24'd0;
        accept(8'd13);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        modulus = 8'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done) begin
                pulses++;
                if (first < 0) first = c;
                seen = {mont_one, r2_mod_n, n_prime};
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL mid_pulses got=%0d want=1", pulses);
        end
        checks++;
        if (first !== 8) begin
            failures++;
            $display("FAIL mid_latency got=%0d want=8", first);
        end
        checks++;
        if (seen !== {8'd9, 8'd3, 8'd59} || error !== 1'b0) begin
            failures++;
            $display("FAIL mid_result got=%h err=%b want=09033b err=0", seen, error);
        end
        $display("mid_run: pulses=%0d results=%h", pulses, seen);
    endtask

    task automatic test_reset_mid_run;
        int pulses;
        int lat;
        pulses = 0;
        accept(8'd13);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstrun_nodone got=%0d busy=%b want=0 busy=0", pulses, busy);
        end
        checks++;
        if ({mont_one, r2_mod_n, n_prime, error} !== 25'd0) begin
            failures++;
            $display("FAIL rstrun_zero got=%0d/%0d/%0d err=%b want=0/0/0 err=0",
                     mont_one, r2_mod_n, n_prime, error);
        end
        accept(8'd13);
        wait_done(lat);
        checks++;
        if ({mont_one, r2_mod_n, n_prime} !== {8'd9, 8'd3, 8'd59} || lat !== 16) begin
            failures++;
            $display("FAIL rstrun_rerun got=%0d/%0d/%0d lat=%0d want=9/3/59 lat=16",
                     mont_one, r2_mod_n, n_prime, lat);
        end
        $display("reset_mid_run: pulses=%0d rerun=%0d/%0d/%0d", pulses, mont_one, r2_mod_n, n_prime);
    endtask

    task automatic test_sweep;
        int lat;
        int em;
        int er;
        int ep;
        int bad;
        bad = 0;
        for (int n = 3; n < 256; n += 2) begin
            em = 256 % n;
            er = 65536 % n;
            ep = 0;
            for (int p = 0; p < 256; p++) begin
                if (((n * p) + 1) % 256 == 0) ep = p;
            end
            accept(8'(n));
            wait_done(lat);
            checks++;
            if (int'(mont_one) !== em || int'(r2_mod_n) !== er || int'(n_prime) !== ep || lat !== 16) begin
                failures++;
                bad++;
                $display("FAIL sweep_n%0d got=%0d/%0d/%0d lat=%0d want=%0d/%0d/%0d lat=16",
                         n, mont_one, r2_mod_n, n_prime, lat, em, er, ep);
            end
        end
        $display("sweep: 127 odd moduli, %0d mismatched", bad);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_vectors;
        test_error;
        test_mid_run;
        test_reset_mid_run;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mont_precompute.md
MONT_PRECOMPUTE -- requirements
Module: mont_precompute

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, giving the modulus and result width in bits; R = 2^WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a precompute for the current modulus; sampled only in IDLE.
REQ-005 SHALL have port modulus, input, WIDTH bits: n; captured on the accepted start.
REQ-006 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the outputs are valid or when error is set.
REQ-008 SHALL have port error, output, 1 bit: set with done when n is even or n == 1.
REQ-009 SHALL have port mont_one, output, WIDTH bits: R mod n, the Montgomery-domain one consumed by the exponentiator.
REQ-010 SHALL have port r2_mod_n, output, WIDTH bits: R^2 mod n, for conversion into the Montgomery domain.
REQ-011 SHALL have port n_prime, output, WIDTH bits: -n^-1 mod R.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE, ERR.
REQ-013 In IDLE with start=1, SHALL capture n and clear error.
REQ-014 From IDLE with start=1, SHALL go to ERR if n[0]==0 or n==1, else to RUN.
REQ-015 On entering RUN, SHALL initialise x=1, iteration count k=0, accumulator t=0 and n_prime accumulator np=0.
REQ-016 Each RUN cycle SHALL compute d = 2x in WIDTH+1 bits, then set x = d-n if d >= n, else x = d.
REQ-017 SHALL maintain the invariant x = 2^(k+1) mod n after iteration k.
REQ-018 In RUN iterations k < WIDTH: if t[k]==0, SHALL set np[k]=1 and t = (t + (n << k)) mod 2^WIDTH; otherwise t and np are unchanged.
REQ-019 On iteration k == WIDTH-1, SHALL register mont_one = the new x value.
REQ-020 On iteration k == 2*WIDTH-1, SHALL register r2_mod_n = the new x value and n_prime = the final np, then go to DONE.
REQ-021 RUN SHALL last exactly 2*WIDTH cycles.
REQ-022 done SHALL be high for exactly one cycle, in DONE; DONE then returns to IDLE.
REQ-023 Latency: if start is accepted at edge E, done SHALL be high during the cycle after edge E+2*WIDTH.
REQ-024 ERR SHALL assert done=1 and error=1 for one cycle (the cycle after the accepting edge) and leave mont_one, r2_mod_n and n_prime unchanged, then return to IDLE.
REQ-025 error SHALL hold its value until the next accepted start.
REQ-026 start while busy=1 SHALL be ignored and not queued.
REQ-027 Changes on modulus after acceptance SHALL have no effect on the operation in progress.
REQ-028 mont_one, r2_mod_n and n_prime SHALL hold their last valid values until overwritten by a later successful run.
REQ-029 A start asserted in the cycle done is high (DONE/ERR) SHALL be ignored; start is accepted only from the following IDLE cycle.

Reset
REQ-030 With rst=1 at a clock edge, SHALL enter IDLE and clear busy, done, error, mont_one, r2_mod_n, n_prime and all internal registers to 0.
REQ-031 Reset mid-RUN SHALL abandon the operation with no done pulse; outputs read 0 afterwards.
REQ-032 rst SHALL take priority over start in the same cycle.

Verification (WIDTH=8)
REQ-033 n=13, start pulse -> after 16 RUN cycles, done pulses once with mont_one=9, r2_mod_n=3, n_prime=59, error=0.
REQ-034 n=255 -> mont_one=1, r2_mod_n=1, n_prime=1; n=3 -> mont_one=1, r2_mod_n=1, n_prime=85.
REQ-035 n=12, then separately n=1 -> done and error high one cycle after accept; busy for 1 cycle; prior results unchanged.
REQ-036 n=13 run; assert start and change modulus to 3 mid-RUN -> result is still the n=13 set, with exactly one done pulse.
REQ-037 rst asserted at RUN cycle 5 -> no done pulse, all outputs 0; a new start with n=13 then completes normally with the REQ-033 values.
REQ-038 Random odd n > 1 (WIDTH=8, all 127 values) -> mont_one*n_inv, r2 and n*n_prime+1 ≡ 0 mod 256 all match the reference model.
